// File: rtl/if_id_queue.sv
// IF/ID instruction buffer: DEPTH-entry circular FIFO of {pc, inst} with valid/ready on both sides.
// Define IF_ID_QUEUE_BYPASS_EN to forward IF straight to ID when the buffer is empty.
module if_id_queue #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush_in,
    input  logic                     if_valid_in,
    input  logic [ADDR_W-1:0]        if_pc,
    input  logic [INST_W-1:0]        if_inst,
    output logic                     if_ready_out,
    output logic                     id_valid_out,
    input  logic                     id_ready_in,
    output logic [ADDR_W-1:0]        id_pc,
    output logic [INST_W-1:0]        id_inst,
    output logic [$clog2(DEPTH):0]   count_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic q_empty;
    logic q_full;
    logic active;
    logic bypass_hit;
    logic wr_en;
    logic rd_en;
    logic [ADDR_W-1:0] head_pc;
    logic [INST_W-1:0] head_inst;

    assign q_empty = (count == '0);
    assign q_full  = (count == CNT_W'(DEPTH));
    assign active  = rdy_in & ~flush_in;

`ifdef IF_ID_QUEUE_BYPASS_EN
    // Empty buffer with IF offering: present the IF word to ID in the same cycle.
    assign bypass_hit = q_empty & if_valid_in;
    assign head_pc    = bypass_hit ? if_pc   : pc_mem[rd_ptr];
    assign head_inst  = bypass_hit ? if_inst : inst_mem[rd_ptr];
`else
    assign bypass_hit = 1'b0;
    assign head_pc    = pc_mem[rd_ptr];
    assign head_inst  = inst_mem[rd_ptr];
`endif

    assign if_ready_out = active & ~q_full;
    assign id_valid_out = active & (~q_empty | bypass_hit);

    // A bypassed word consumed by ID is never written; storage is only read when it holds something.
    assign wr_en = if_valid_in & if_ready_out & ~(bypass_hit & id_ready_in);
    assign rd_en = id_valid_out & id_ready_in & ~q_empty;

    assign id_pc     = id_valid_out ? head_pc   : '0;
    assign id_inst   = id_valid_out ? head_inst : '0;
    assign count_out = count;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                // NOTE: non-blocking assignments keep every pointer reading its pre-edge value.
                if (wr_en) wr_ptr <= wr_ptr + 1'b1;
                if (rd_en) rd_ptr <= rd_ptr + 1'b1;
                count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
            end
        end
    end

    // NOTE: storage has no reset; entries are only ever read behind a valid count, so the
    // array maps onto plain RAM/flops without a reset network.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            pc_mem[wr_ptr]   <= if_pc;
            inst_mem[wr_ptr] <= if_inst;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: queue-based reference model compared every cycle,
// plus hand-computed directed expectations. Honours IF_ID_QUEUE_BYPASS_EN like the design.
module tb_if_id_queue;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam int DEPTH  = 4;

    logic              clk_in;
    logic              rst_in;
    logic              rdy_in;
    logic              flush_in;
    logic              if_valid_in;
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;
    logic              if_ready_out;
    logic              id_valid_out;
    logic              id_ready_in;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;
    logic [$clog2(DEPTH):0] count_out;

    if_id_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .flush_in     (flush_in),
        .if_valid_in  (if_valid_in),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_ready_out (if_ready_out),
        .id_valid_out (id_valid_out),
        .id_ready_in  (id_ready_in),
        .id_pc        (id_pc),
        .id_inst      (id_inst),
        .count_out    (count_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    entry_t mq[$];
    int     n_pass  = 0;
    int     n_total = 0;
    logic   cmp_en  = 1'b0;

`ifdef IF_ID_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [INST_W-1:0] mk_inst(input logic [ADDR_W-1:0] pc);
        return pc ^ 32'hDEAD_0013;
    endfunction

    function automatic bit m_ready();
        return rdy_in && !flush_in && (mq.size() < DEPTH);
    endfunction

    function automatic bit m_valid();
        return rdy_in && !flush_in && (mq.size() > 0 || (BYPASS && if_valid_in));
    endfunction

    // Reference model: occupancy is simply the length of a queue of accepted words.
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mq.delete();
        end else if (rdy_in && flush_in) begin
            mq.delete();
        end else if (rdy_in) begin
            automatic bit push = if_valid_in && m_ready();
            automatic bit pop  = m_valid() && id_ready_in;
            automatic bit byp  = (mq.size() == 0) && pop;
            if (pop && mq.size() > 0) void'(mq.pop_front());
            if (push && !byp) mq.push_back('{pc: if_pc, inst: if_inst});
        end
    end

    always @(negedge clk_in) begin
        if (cmp_en) begin
            automatic bit v = m_valid();
            automatic logic [ADDR_W-1:0] epc = '0;
            automatic logic [INST_W-1:0] ein = '0;
            if (v) begin
                epc = (mq.size() > 0) ? mq[0].pc   : if_pc;
                ein = (mq.size() > 0) ? mq[0].inst : if_inst;
            end
            check("m_if_ready", 64'(if_ready_out), 64'(m_ready()));
            check("m_id_valid", 64'(id_valid_out), 64'(v));
            check("m_id_pc",    64'(id_pc),        64'(epc));
            check("m_id_inst",  64'(id_inst),      64'(ein));
            check("m_count",    64'(count_out),    64'(mq.size()));
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_n(input int n, input logic [ADDR_W-1:0] base);
        for (int i = 0; i < n; i++) begin
            if_valid_in = 1'b1;
            if_pc       = base + ADDR_W'(4 * i);
            if_inst     = mk_inst(if_pc);
            step();
        end
        if_valid_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        automatic logic [ADDR_W-1:0] drain_pc [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};

        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; if_valid_in = 1'b0;
        if_pc = '0; if_inst = '0; id_ready_in = 1'b0;
        #1 rst_in = 1'b1;
        #1;
        check("rst_count",    64'(count_out),    64'd0);
        check("rst_id_valid", 64'(id_valid_out), 64'd0);
        check("rst_id_pc",    64'(id_pc),        64'd0);
        check("rst_if_ready", 64'(if_ready_out), 64'd1);
        step(); step();
        rst_in = 1'b0;
        cmp_en = 1'b1;

        // Fill to DEPTH with ID stalled; fifth word must be held off.
        id_ready_in = 1'b0;
        push_n(4, 32'h0);
        if_valid_in = 1'b1; if_pc = 32'h10; if_inst = mk_inst(32'h10);
        #1;
        check("full_count",    64'(count_out),    64'd4);
        check("full_if_ready", 64'(if_ready_out), 64'd0);
        check("full_id_pc",    64'(id_pc),        64'h0);
        step();
        check("full_hold_count", 64'(count_out), 64'd4);

        // Drain with 0x10 offered until accepted; pointers wrap past DEPTH.
        id_ready_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if_valid_in = (k < 2);
            #1;
            check("drain_id_pc", 64'(id_pc), 64'(drain_pc[k]));
            step();
        end
        if_valid_in = 1'b0;
        check("drain_count", 64'(count_out), 64'd0);

        // Flush with both handshakes requested.
        id_ready_in = 1'b0;
        push_n(3, 32'h20);
        flush_in = 1'b1; if_valid_in = 1'b1; if_pc = 32'h2C; if_inst = mk_inst(32'h2C); id_ready_in = 1'b1;
        #1;
        check("flush_if_ready", 64'(if_ready_out), 64'd0);
        check("flush_id_valid", 64'(id_valid_out), 64'd0);
        step();
        flush_in = 1'b0; if_valid_in = 1'b0; id_ready_in = 1'b0;
        #1;
        check("post_flush_count",    64'(count_out),    64'd0);
        check("post_flush_id_valid", 64'(id_valid_out), 64'd0);
        check("post_flush_id_inst",  64'(id_inst),      64'd0);
        check("post_flush_if_ready", 64'(if_ready_out), 64'd1);

        // rdy_in low freezes everything, flush included.
        push_n(2, 32'h40);
        rdy_in = 1'b0; if_valid_in = 1'b1; if_pc = 32'h48; if_inst = mk_inst(32'h48); id_ready_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            flush_in = (k == 1);
            #1;
            check("frz_if_ready", 64'(if_ready_out), 64'd0);
            check("frz_id_valid", 64'(id_valid_out), 64'd0);
            check("frz_count",    64'(count_out),    64'd2);
            step();
        end
        rdy_in = 1'b1; flush_in = 1'b0; if_valid_in = 1'b0; id_ready_in = 1'b0;
        #1;
        check("thaw_id_pc",  64'(id_pc),     64'h40);
        check("thaw_count",  64'(count_out), 64'd2);
        rdy_in = 1'b0; flush_in = 1'b1;
        step();
        rdy_in = 1'b1;
        #1;
        check("held_flush_count", 64'(count_out), 64'd2);
        step();
        flush_in = 1'b0;
        #1;
        check("held_flush_clear", 64'(count_out), 64'd0);

        // Asynchronous reset between edges with two entries held.
        push_n(2, 32'h50);
        #3 rst_in = 1'b1;
        #1;
        check("arst_count",    64'(count_out),    64'd0);
        check("arst_id_valid", 64'(id_valid_out), 64'd0);
        check("arst_id_pc",    64'(id_pc),        64'd0);
        step();
        rst_in = 1'b0;

        // Empty-queue latency: bypass forwards same cycle, otherwise one cycle later.
        if_valid_in = 1'b1; if_pc = 32'h80; if_inst = mk_inst(32'h80); id_ready_in = 1'b1;
        #1;
        check("lat0_id_valid", 64'(id_valid_out), BYPASS ? 64'd1 : 64'd0);
        check("lat0_id_pc",    64'(id_pc),        BYPASS ? 64'h80 : 64'h0);
        step();
        if_valid_in = 1'b0;
        #1;
        check("lat1_count",    64'(count_out),    BYPASS ? 64'd0 : 64'd1);
        check("lat1_id_pc",    64'(id_pc),        BYPASS ? 64'h0 : 64'h80);
        step();
        check("lat2_count", 64'(count_out), 64'd0);

        // Mixed traffic: simultaneous push/pop at assorted occupancies.
        for (int i = 0; i < 24; i++) begin
            if_valid_in = (i % 3 != 0);
            id_ready_in = (i % 4 < 2);
            if_pc       = 32'h100 + 32'(4 * i);
            if_inst     = mk_inst(if_pc);
            step();
        end
        if_valid_in = 1'b0; id_ready_in = 1'b1;
        repeat (6) step();
        check("soak_drained", 64'(count_out), 64'd0);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
